if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage that feeds the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a request/grant/response handshake. It holds the returned instruction and its PC+4 in a one-entry output buffer, with a skid register for responses that arrive while ID is stalled. It drives the IF/ID flush input on empty cycles and on redirects, and it discards wrong-path responses after a branch or jump redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP, 32'h0000_0000, Instruction_Out value while the buffer is empty after reset
- CLOCK  in  1  rising-edge clock; only clock
- RESET  in  1  synchronous, active-high reset
- STALL  in  1  from hazard unit; 1 = ID does not consume this cycle (same meaning as the IF/ID STALL)
- REDIRECT  in  1  1 = taken branch/jump; fetch restarts at REDIRECT_PC
- REDIRECT_PC  in  32  redirect target
- MEM_REQ  out  1  request valid
- MEM_ADDR  out  32  request address (= PC)
- MEM_GNT  in  1  memory accepts the request this cycle
- MEM_RVALID  in  1  response valid; at most one per granted request, ≥1 cycle after grant
- MEM_RDATA  in  32  response instruction
- Instruction_Out  out  32  buffered instruction to IF/ID Instruction_In
- PCPlus4_Out  out  32  buffered instruction address + 4, to IF/ID PCPlus4_In
- FETCH_VALID  out  1  output buffer holds a valid instruction
- FETCH_FLUSH  out  1  to IF/ID RESET; combinational, = !FETCH_VALID | REDIRECT

## Operation
- Registers: PC, state, output buffer (Instruction_Out, PCPlus4_Out, FETCH_VALID), skid (32 bits).
- Consume event: FETCH_VALID=1 & STALL=0. It clears FETCH_VALID unless the buffer is reloaded in the same cycle.
- Buffer free: FETCH_VALID=0 | STALL=0.
- S_REQ: MEM_REQ = !REDIRECT; MEM_ADDR = PC. On MEM_GNT & !REDIRECT → S_WAIT.
- S_WAIT: on MEM_RVALID with buffer free, load the buffer (MEM_RDATA, PC+4, valid), set PC ← PC+4, go → S_REQ. On MEM_RVALID with buffer not free, set skid ← MEM_RDATA and go → S_SKID.
- S_SKID: when STALL=0, load the buffer from skid with PCPlus4_Out ← PC+4, set PC ← PC+4, go → S_REQ.
- S_DROP: on MEM_RVALID, discard the data and go → S_REQ.
- REDIRECT overrides everything except RESET:
  - PC ← REDIRECT_PC and FETCH_VALID ← 0; STALL is ignored.
  - Next state: S_REQ→S_REQ; S_WAIT without RVALID→S_DROP; S_WAIT with RVALID→S_REQ, data discarded; S_SKID→S_REQ, skid discarded; S_DROP→S_DROP, unless RVALID that cycle→S_REQ.
- Only one request is ever outstanding. A request is never withdrawn once asserted, except on a REDIRECT cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no alignment check.
- MEM_MEM_RVALID outside S_WAIT/S_DROP is a protocol error and is ignored.

## Timing
- Reset (RESET=1 at an edge):
  - PC=RESET_PC, state=S_REQ, FETCH_VALID=0, Instruction_Out=NOP, PCPlus4_Out=0, skid=0.
  - While RESET=1: MEM_REQ=0 and FETCH_FLUSH=1.
- Reset mid-transaction: an outstanding response is not tracked. Memory must be reset in the same cycle.
- Latency: the buffer loads on the edge that samples MEM_RVALID. FETCH_VALID is high in the following cycle.
- Back-to-back with GNT in the request cycle and RVALID 1 cycle later: one instruction per 2 cycles.
- Stall: buffer and PC hold. At most one extra response is captured in skid. No request issues while in S_SKID.
- Redirect: the first request to REDIRECT_PC is asserted in the cycle after REDIRECT. In S_DROP it is asserted the cycle after the stale RVALID.
- FETCH_FLUSH is high in the REDIRECT cycle itself, so IF/ID captures a bubble.

## Test plan
- Reset then free-running, GNT=1, RVALID 1 cycle after grant, RDATA=addr^32'hA5A5_0000, STALL=0 → requests at addresses 0,4,8,12. Each instruction appears with PCPlus4_Out = addr+4. FETCH_VALID toggles 1,0,1,0…
- Stall in S_WAIT: buffer holds the instruction from addr 0x0; STALL=1; RVALID returns 0x1111_1111 for 0x4 → skid holds it, MEM_REQ=0. STALL=0 for one cycle → buffer=0x1111_1111, PCPlus4_Out=0x8, next request at 0x8.
- Redirect with a response in flight: request 0x10 granted; REDIRECT=1, REDIRECT_PC=0x200 before RVALID → the response for 0x10 is discarded and never shown. FETCH_FLUSH=1 during redirect. The next MEM_ADDR is 0x200 and the resulting PCPlus4_Out is 0x204.
- Redirect coincident with RVALID and STALL=1 → the data is dropped, FETCH_VALID=0 next cycle, and a request to REDIRECT_PC is asserted next cycle.
- Wrap: RESET_PC=32'hFFFF_FFFC → the first instruction has PCPlus4_Out=0, and the second request is at 0x0.
- Synchronous reset asserted in S_SKID with STALL=1 → next cycle FETCH_VALID=0, Instruction_Out=NOP and MEM_REQ=0. After release, the first request is at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC and issues one request at a time.
// Holds the returned instruction and its PC+4 in a one-entry output buffer.
// A skid register catches a response that arrives while ID is stalled.
// Responses that were requested before a redirect are dropped.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] Instruction_Out,
  output logic [31:0] PCPlus4_Out,
  output logic        FETCH_VALID,
  output logic        FETCH_FLUSH
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_SKID = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   skid_q, skid_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_plus4;
  logic              consume;
  logic              buf_free;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign consume  = valid_q & ~STALL;
  assign buf_free = ~valid_q | ~STALL;

  // Memory request and IF/ID flush are combinational by interface contract.
  assign MEM_REQ         = (state_q == S_REQ) & ~REDIRECT & ~RESET;
  assign MEM_ADDR        = pc_q;
  assign FETCH_FLUSH     = ~valid_q | REDIRECT | RESET;
  assign Instruction_Out = instr_q;
  assign PCPlus4_Out     = pc4_q;
  assign FETCH_VALID     = valid_q;

  // State, PC, output buffer and skid registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pc4_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, buffer load and redirect override.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    skid_d  = skid_q;
    valid_d = valid_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (MEM_GNT) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (MEM_RVALID) begin
          if (buf_free) begin
            instr_d = MEM_RDATA;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_REQ;
          end else begin
            skid_d  = MEM_RDATA;
            state_d = S_SKID;
          end
        end
      end
      S_SKID: begin
        if (!STALL) begin
          instr_d = skid_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (MEM_RVALID) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect discards anything in flight or buffered; a stale response
    // still owed by memory is absorbed in S_DROP.
    if (REDIRECT) begin
      pc_d    = REDIRECT_PC;
      valid_d = 1'b0;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      skid_d  = skid_q;
      if ((state_q == S_WAIT || state_q == S_DROP) && !MEM_RVALID) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst, rst2;
  logic        stall, redirect, gnt, rvalid;
  logic [31:0] rpc, rdata;
  logic        req, valid, flush;
  logic [31:0] addr, instr, pc4;
  logic        req2, valid2, flush2;
  logic [31:0] addr2, instr2, pc42;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
    .CLOCK(clk), .RESET(rst), .STALL(stall), .REDIRECT(redirect),
    .REDIRECT_PC(rpc), .MEM_REQ(req), .MEM_ADDR(addr), .MEM_GNT(gnt),
    .MEM_RVALID(rvalid), .MEM_RDATA(rdata), .Instruction_Out(instr),
    .PCPlus4_Out(pc4), .FETCH_VALID(valid), .FETCH_FLUSH(flush)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP(32'h0000_0000)) dut_wrap (
    .CLOCK(clk), .RESET(rst2), .STALL(stall), .REDIRECT(redirect),
    .REDIRECT_PC(rpc), .MEM_REQ(req2), .MEM_ADDR(addr2), .MEM_GNT(gnt),
    .MEM_RVALID(rvalid), .MEM_RDATA(rdata), .Instruction_Out(instr2),
    .PCPlus4_Out(pc42), .FETCH_VALID(valid2), .FETCH_FLUSH(flush2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        flush;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rq, input logic [31:0] a, input logic v,
                              input logic [31:0] i, input logic [31:0] p, input logic f);
    vec_t t;
    t.gnt = g; t.rvalid = rv; t.rdata = rd; t.req = rq; t.addr = a;
    t.valid = v; t.instr = i; t.pc4 = p; t.flush = f;
    return t;
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic s, input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdr, input logic [31:0] rp);
    stall = s; gnt = g; rvalid = rv; rdata = rd; redirect = rdr; rpc = rp;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    smp;
    chk1("rst_req", req, 1'b0);
    chk1("rst_flush", flush, 1'b1);
    nxt;
    smp;
    chk1("rst_valid", valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk1("rst_req_held", req, 1'b0);
    nxt;
    rst = 1'b0;
  endtask

  // Fetch 0x0 into the buffer, then stall while 0x4 returns into the skid.
  task automatic to_skid;
    drv(0, 1, 0, 0, 0, 0);
    smp; chk("sk_addr0", addr, 32'h0); chk1("sk_req0", req, 1'b1);
    nxt;
    drv(0, 0, 1, 32'hDEAD_0000, 0, 0);
    nxt;
    drv(1, 1, 0, 0, 0, 0);
    smp; chk1("sk_valid", valid, 1'b1); chk("sk_addr4", addr, 32'h4);
    nxt;
    drv(1, 0, 1, 32'h1111_1111, 0, 0);
    nxt;
    drv(1, 0, 0, 0, 0, 0);
    smp;
    chk1("sk_noreq", req, 1'b0);
    chk("sk_hold_instr", instr, 32'hDEAD_0000);
    chk("sk_hold_pc4", pc4, 32'h4);
    nxt;
  endtask

  vec_t tbl[9];

  // Random-phase model state
  ent_t        q[$];
  logic [31:0] exp_addr;
  logic        outst, stale;
  int          cnt;
  logic [31:0] o_addr;
  int          consumed;

  initial begin
    tbl[0] = mk(1, 0, 32'h0,         1, 32'd0,  0, 32'h0,         32'd0,  1);
    tbl[1] = mk(1, 1, 32'hA5A5_0000, 0, 32'd0,  0, 32'h0,         32'd0,  1);
    tbl[2] = mk(1, 0, 32'h0,         1, 32'd4,  1, 32'hA5A5_0000, 32'd4,  0);
    tbl[3] = mk(1, 1, 32'hA5A5_0004, 0, 32'd4,  0, 32'hA5A5_0000, 32'd4,  1);
    tbl[4] = mk(1, 0, 32'h0,         1, 32'd8,  1, 32'hA5A5_0004, 32'd8,  0);
    tbl[5] = mk(1, 1, 32'hA5A5_0008, 0, 32'd8,  0, 32'hA5A5_0004, 32'd8,  1);
    tbl[6] = mk(1, 0, 32'h0,         1, 32'd12, 1, 32'hA5A5_0008, 32'd12, 0);
    tbl[7] = mk(1, 1, 32'hA5A5_000C, 0, 32'd12, 0, 32'hA5A5_0008, 32'd12, 1);
    tbl[8] = mk(0, 0, 32'h0,         1, 32'd16, 1, 32'hA5A5_000C, 32'd16, 0);

    rst2 = 1'b1;
    do_reset;

    // Free-running fetch, one instruction every two cycles
    for (int i = 0; i < 9; i++) begin
      drv(0, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, 0, 0);
      smp;
      chk1($sformatf("tbl%0d_req", i), req, tbl[i].req);
      chk($sformatf("tbl%0d_addr", i), addr, tbl[i].addr);
      chk1($sformatf("tbl%0d_valid", i), valid, tbl[i].valid);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].instr);
      chk($sformatf("tbl%0d_pc4", i), pc4, tbl[i].pc4);
      chk1($sformatf("tbl%0d_flush", i), flush, tbl[i].flush);
      nxt;
    end

    // Stall with a response captured in the skid, then release for one cycle
    do_reset;
    to_skid;
    drv(0, 0, 0, 0, 0, 0);
    nxt;
    drv(1, 0, 0, 0, 0, 0);
    smp;
    chk1("stall_valid", valid, 1'b1);
    chk("stall_instr", instr, 32'h1111_1111);
    chk("stall_pc4", pc4, 32'h8);
    chk1("stall_req", req, 1'b1);
    chk("stall_addr", addr, 32'h8);
    nxt;

    // Redirect while a response is in flight
    do_reset;
    drv(0, 0, 0, 0, 1, 32'h10);
    smp; chk1("rd0_flush", flush, 1'b1); chk1("rd0_req", req, 1'b0);
    nxt;
    drv(0, 1, 0, 0, 0, 0);
    smp; chk1("rd1_req", req, 1'b1); chk("rd1_addr", addr, 32'h10);
    nxt;
    drv(0, 0, 0, 0, 1, 32'h200);
    smp; chk1("rd2_flush", flush, 1'b1); chk1("rd2_req", req, 1'b0);
    nxt;
    drv(0, 0, 1, 32'hBAD0_0010, 0, 0);
    smp; chk1("rd3_req", req, 1'b0); chk1("rd3_valid", valid, 1'b0);
    nxt;
    drv(0, 1, 0, 0, 0, 0);
    smp; chk1("rd4_req", req, 1'b1); chk("rd4_addr", addr, 32'h200);
    chk1("rd4_valid", valid, 1'b0);
    nxt;
    drv(0, 0, 1, 32'h0000_0200, 0, 0);
    nxt;
    // Redirect coincident with RVALID while stalled
    drv(1, 1, 0, 0, 0, 0);
    smp; chk1("rd6_valid", valid, 1'b1); chk("rd6_pc4", pc4, 32'h204);
    chk("rd6_instr", instr, 32'h0000_0200);
    nxt;
    drv(1, 0, 1, 32'h0000_0204, 1, 32'h300);
    smp; chk1("rd7_flush", flush, 1'b1);
    nxt;
    drv(1, 0, 0, 0, 0, 0);
    smp; chk1("rd8_valid", valid, 1'b0); chk1("rd8_req", req, 1'b1);
    chk("rd8_addr", addr, 32'h300);
    nxt;

    // PC wrap from 0xFFFF_FFFC
    rst = 1'b1; rst2 = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    nxt;
    rst2 = 1'b0;
    drv(0, 1, 0, 0, 0, 0);
    smp; chk1("wr_req0", req2, 1'b1); chk("wr_addr0", addr2, 32'hFFFF_FFFC);
    nxt;
    drv(0, 0, 1, 32'hCAFE_0000, 0, 0);
    nxt;
    drv(0, 0, 0, 0, 0, 0);
    smp;
    chk1("wr_valid", valid2, 1'b1);
    chk("wr_instr", instr2, 32'hCAFE_0000);
    chk("wr_pc4", pc42, 32'h0);
    chk1("wr_req1", req2, 1'b1);
    chk("wr_addr1", addr2, 32'h0);
    nxt;
    rst2 = 1'b1;

    // Synchronous reset while holding a response in the skid
    do_reset;
    to_skid;
    rst = 1'b1;
    drv(1, 0, 0, 0, 0, 0);
    smp; chk1("rs_req", req, 1'b0); chk1("rs_flush", flush, 1'b1);
    nxt;
    smp; chk1("rs_valid", valid, 1'b0); chk("rs_instr", instr, 32'h0);
    chk1("rs_req_held", req, 1'b0);
    nxt;
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    smp; chk1("rs_req_rel", req, 1'b1); chk("rs_addr_rel", addr, 32'h0);
    nxt;

    // Randomized run against the transaction-level model
    do_reset;
    q.delete();
    exp_addr = 32'h0;
    outst = 1'b0; stale = 1'b0; cnt = 0; o_addr = 32'h0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        s, r, g, rv;
      logic [31:0] rp;
      s  = ($urandom % 10) < 3;
      r  = ($urandom % 12) == 0;
      rp = 32'(($urandom % 1024) * 4);
      g  = ($urandom % 3) != 0;
      rv = outst && (cnt == 0);
      drv(s, g, rv, rv ? mem_data(o_addr) : 32'h0, r, rp);
      smp;
      chk1("rnd_flush", flush, ~valid | redirect);
      chk1("rnd_valid", valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_instr", instr, q[0].instr);
        chk("rnd_pc4", pc4, q[0].pc4);
      end
      chk1("rnd_single_outstanding", req & outst, 1'b0);
      if (req && gnt) begin
        chk("rnd_req_addr", addr, exp_addr);
      end
      // Model update for the coming edge
      if (q.size() != 0 && !stall && !redirect) begin
        void'(q.pop_front());
        consumed++;
      end
      if (rvalid) begin
        if (!stale && !redirect) begin
          ent_t e;
          e.instr = mem_data(o_addr);
          e.pc4   = o_addr + 32'd4;
          q.push_back(e);
        end
        outst = 1'b0;
        stale = 1'b0;
      end else if (outst) begin
        cnt--;
      end
      if (redirect) begin
        q.delete();
        exp_addr = rpc;
        if (outst) stale = 1'b1;
      end
      if (req && gnt) begin
        outst    = 1'b1;
        stale    = 1'b0;
        o_addr   = addr;
        cnt      = int'($urandom % 3);
        exp_addr = addr + 32'd4;
      end
      nxt;
    end
    chk1("rnd_progress", consumed > 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
